// File: rtl/csr_mgr_pkg.sv
// Shared types and address map for the app CSR MMIO bridge.
// Stats counter width is used only when APP_CSR_MMIO_STATS_EN is defined.
package csr_mgr_pkg;

    localparam int NUM_CSR_MGR_COUNTER_BITS = 40;
    typedef logic [NUM_CSR_MGR_COUNTER_BITS-1:0] t_csr_mgr_counter;

    localparam int unsigned NUM_APP_CSRS_DEFAULT = 20;

    // Byte offsets of the fixed registers in front of the app CSR window
    localparam logic [17:0] DFH_BYTE      = 18'h00;
    localparam logic [17:0] AFU_ID_L_BYTE = 18'h08;
    localparam logic [17:0] AFU_ID_H_BYTE = 18'h10;
    localparam logic [17:0] STATS_WR_BYTE = 18'h18;
    localparam logic [17:0] STATS_RD_BYTE = 18'h20;

    typedef enum logic [1:0] {
        MMIO_LEN_4B = 2'd0,
        MMIO_LEN_8B = 2'd1
    } t_mmio_len;

    // Every encoding other than 4B is treated as an 8B access
    function automatic logic is_4b(input logic [1:0] len);
        return len == MMIO_LEN_4B;
    endfunction

    // 8B-aligned byte address of a DWORD address
    function automatic logic [17:0] qword_byte_addr(input logic [15:0] dw_addr);
        return {dw_addr[15:1], 3'b000};
    endfunction

endpackage

// File: rtl/app_csr_rd_mux.sv
// Combinational read-data select for the MMIO read pipeline: address map
// decode plus 4B DWORD extraction.
module app_csr_rd_mux
    import csr_mgr_pkg::*;
#(
    parameter int unsigned NUM_APP_CSRS      = NUM_APP_CSRS_DEFAULT,
    parameter int unsigned APP_CSR_BASE_BYTE = 'h100,
    parameter logic [63:0] DFH_VALUE         = 64'h1000_0100_0000_0000
) (
    input  logic [15:0]                 addr,
    input  logic [1:0]                  len,
    input  logic [127:0]                afu_id,
    input  logic [64*NUM_APP_CSRS-1:0]  rd_csr_data,
    input  t_csr_mgr_counter            wr_count,
    input  t_csr_mgr_counter            rd_count,
    output logic [63:0]                 data
);

    localparam int IDX_W = $clog2(NUM_APP_CSRS) + 1;

    logic [17:0]      ba;
    logic             in_app;
    logic [IDX_W-1:0] idx;
    logic [63:0]      qword;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ba     = qword_byte_addr(addr);
        in_app = (32'(ba) >= APP_CSR_BASE_BYTE) &&
                 (32'(ba) <  APP_CSR_BASE_BYTE + 8 * NUM_APP_CSRS);
        idx    = IDX_W'((32'(ba) - APP_CSR_BASE_BYTE) >> 3);
        qword  = '0;
        if (in_app) begin
            for (int i = 0; i < int'(NUM_APP_CSRS); i++) begin
                if (idx == IDX_W'(i)) qword = rd_csr_data[64*i +: 64];
            end
        end else begin
            case (ba)
                DFH_BYTE:      qword = DFH_VALUE;
                AFU_ID_L_BYTE: qword = afu_id[63:0];
                AFU_ID_H_BYTE: qword = afu_id[127:64];
                STATS_WR_BYTE: qword = 64'(wr_count);
                STATS_RD_BYTE: qword = 64'(rd_count);
                default:       qword = '0;
            endcase
        end

        if (is_4b(len)) data = {32'b0, addr[0] ? qword[63:32] : qword[31:0]};
        else            data = qword;
    end

endmodule

// File: rtl/app_csr_mmio_bridge.sv
// CCI-P MMIO terminator for the app CSR block: write strobes at latency 1,
// read responses at latency 2. Optional MMIO counters: APP_CSR_MMIO_STATS_EN.
module app_csr_mmio_bridge
    import csr_mgr_pkg::*;
#(
    parameter int unsigned NUM_APP_CSRS      = NUM_APP_CSRS_DEFAULT,
    parameter int unsigned APP_CSR_BASE_BYTE = 'h100,
    parameter logic [63:0] DFH_VALUE         = 64'h1000_0100_0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mmio_wr_valid,
    input  logic                        mmio_rd_valid,
    input  logic [15:0]                 mmio_addr,
    input  logic [1:0]                  mmio_len,
    input  logic [8:0]                  mmio_tid,
    input  logic [63:0]                 mmio_wdata,
    input  logic [127:0]                afu_id,
    input  logic [64*NUM_APP_CSRS-1:0]  rd_csr_data,
    output logic [NUM_APP_CSRS-1:0]     wr_csr_en,
    output logic [63:0]                 wr_csr_data,
    output logic                        rsp_valid,
    output logic [8:0]                  rsp_tid,
    output logic [63:0]                 rsp_data
);

    localparam int IDX_W = $clog2(NUM_APP_CSRS) + 1;

    logic [17:0]             wr_ba;
    logic                    wr_hit;
    logic [IDX_W-1:0]        wr_idx;
    logic [NUM_APP_CSRS-1:0] wr_en_next;
    logic [63:0]             wr_data_next;

    always_comb begin
        wr_ba  = qword_byte_addr(mmio_addr);
        // A 4B write to the upper DWORD of a CSR is dropped entirely
        wr_hit = mmio_wr_valid && !(is_4b(mmio_len) && mmio_addr[0]) &&
                 (32'(wr_ba) >= APP_CSR_BASE_BYTE) &&
                 (32'(wr_ba) <  APP_CSR_BASE_BYTE + 8 * NUM_APP_CSRS);
        wr_idx = IDX_W'((32'(wr_ba) - APP_CSR_BASE_BYTE) >> 3);
        wr_en_next = '0;
        for (int i = 0; i < int'(NUM_APP_CSRS); i++) begin
            wr_en_next[i] = wr_hit && (wr_idx == IDX_W'(i));
        end
        wr_data_next = is_4b(mmio_len) ? {32'b0, mmio_wdata[31:0]} : mmio_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_csr_en   <= '0;
            wr_csr_data <= '0;
        end else begin
            wr_csr_en <= wr_en_next;
            if (|wr_en_next) wr_csr_data <= wr_data_next;
        end
    end

    // Read stage 1: request capture
    logic        s1_valid;
    logic [15:0] s1_addr;
    logic [1:0]  s1_len;
    logic [8:0]  s1_tid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_len   <= '0;
            s1_tid   <= '0;
        end else begin
            s1_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                s1_addr <= mmio_addr;
                s1_len  <= mmio_len;
                s1_tid  <= mmio_tid;
            end
        end
    end

    t_csr_mgr_counter wr_count;
    t_csr_mgr_counter rd_count;

`ifdef APP_CSR_MMIO_STATS_EN
    // Reads count at stage 1 so a read of the read counter sees only earlier reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (mmio_wr_valid) wr_count <= wr_count + 1'b1;
            if (s1_valid)      rd_count <= rd_count + 1'b1;
        end
    end
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

    logic [63:0] rd_mux_data;

    app_csr_rd_mux #(
        .NUM_APP_CSRS      (NUM_APP_CSRS),
        .APP_CSR_BASE_BYTE (APP_CSR_BASE_BYTE),
        .DFH_VALUE         (DFH_VALUE)
    ) u_rd_mux (
        .addr        (s1_addr),
        .len         (s1_len),
        .afu_id      (afu_id),
        .rd_csr_data (rd_csr_data),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .data        (rd_mux_data)
    );

    // Read stage 2: response register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_tid  <= s1_tid;
                rsp_data <= rd_mux_data;
            end
        end
    end

endmodule
